aer_lrf_stride_dispatcher: RTL and testbench
============================================

# aer_lrf_stride_dispatcher

Sequential successor to the combinational LRF mapper. It accepts one input AER event at a time from the feature-map side and computes every core whose local receptive field covers the pixel, with configurable stride and zero padding. It then drives a registered, per-core 4-phase request to each target core and returns the input ACK only after every target has completed its handshake. It sits between the layer's input AER bus and the CORE_H×CORE_W core array.

## Interface
- FM_W, 32: input feature-map width
- FM_H, 32: input feature-map height
- FM_C, 16: input channel count
- LRF_W, 3: receptive-field width
- LRF_H, 3: receptive-field height
- STRIDE, 2: stride, applied to both axes, ≥1
- PAD, 1: zero padding on each border, < LRF_W and < LRF_H
- IN_AER_WIDTH, 16: input event width; IDX = low IN_AER_WIDTH-2 bits = {c, y, x}
- OUT_AER_WIDTH, 10: output event width; must satisfy C_BITS+DY_BITS+DX_BITS ≤ OUT_AER_WIDTH-2
- Derived: CORE_W = (FM_W+2·PAD−LRF_W)/STRIDE+1 (16); CORE_H likewise (16); N = CORE_W·CORE_H; X_BITS=$clog2(FM_W), DX_BITS=$clog2(LRF_W), etc.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- MAP_IN_AERIN_REQ  in  1  input request, 4-phase
- MAP_IN_AERIN_EVENT  in  IN_AER_WIDTH  input event; bits [top:top-1] = type
- MAP_IN_AERIN_IDX  in  IN_AER_WIDTH-2  {c, y, x}
- MAP_IN_AERIN_ACK  out  1  input acknowledge, registered
- MAP_OUT_AERIN_REQ  out  N  per-core request, registered
- MAP_OUT_AERIN_EVENT  out  N×OUT_AER_WIDTH  per-core event, registered
- MAP_OUT_AERIN_IDX  out  N×(OUT_AER_WIDTH-2)  per-core local index, registered
- MAP_OUT_AERIN_ACK  in  N  per-core acknowledge
- BUSY  out  1  FSM not in IDLE
- MAPPED_CNT  out  16  completed type-00 events, wrapping

## Operation
- **Event types:**
  - 00: neuron event, mapped to its target cores.
  - 01 / 10: broadcast to all N cores with IDX=0 and EVENT={type, all ones}.
  - 11: dropped. No core request is issued; the input is ACKed normally.
- **Mapping, per axis:**
  - x' = x+PAD.
  - Core column ox is a target iff 0 ≤ x'−ox·STRIDE < LRF_W and ox < CORE_W.
  - Local offset dx = x'−ox·STRIDE.
  - The y axis follows the same rule, giving oy and dy.
  - Core id = oy·CORE_W+ox.
  - Target mask = AND of the column and row hits.
  - Target IDX = {c, dy, dx}, zero-extended. Target EVENT = {type, IDX}.
- **Empty target mask:** possible when STRIDE > LRF_W, or when a pixel falls only in the padding region. The FSM goes straight to input ACK.
- **FSM:**
  - IDLE: on REQ=1, latch the fields and go to MAP.
  - MAP: compute the mask and load the output registers. Go to ISSUE if the mask is nonzero, otherwise to IN_ACK.
  - ISSUE: each core's REQ is cleared on the edge after its ACK is sampled high. When all REQs are low, go to DRAIN.
  - DRAIN: wait until every ACK in the latched mask is low, then go to IN_ACK.
  - IN_ACK: MAP_IN_AERIN_ACK=1. When input REQ is sampled low, drop ACK and go to IDLE. MAPPED_CNT increments on that edge if type=00.
- Input IDX/EVENT may change once ACK is high. Latched copies are used throughout.
- Non-target cores keep REQ=0, IDX=0, EVENT={2'b11, all ones}.
- Core ACK bits outside the mask are ignored.

## Timing
- **Reset (async, rst_n=0):**
  - FSM in IDLE.
  - All REQ=0, IDX=0, EVENT={2'b11, all ones}.
  - MAP_IN_AERIN_ACK=0, BUSY=0, MAPPED_CNT=0.
  - Reset asserted mid-transaction aborts it immediately. No ACK is ever issued for the aborted event.
- **Latency:**
  - Input REQ sampled at edge E → MAP at E+1 → target REQs high after edge E+2.
  - Minimum input REQ→ACK is 5 edges when the cores ACK on the next cycle.
  - With an empty mask, ACK rises after edge E+2.
- A core ACK already high when its REQ rises is accepted. Its REQ drops on the next edge.
- Cores complete in any order.
- A new input REQ is not sampled until the FSM returns to IDLE.
- MAPPED_CNT wraps from 0xFFFF to 0.

## Test plan
- Defaults, x=0, y=0, c=3, type 00 → only core 0 gets REQ, IDX=0x35, EVENT=10'h035. ACK core 0 → input ACK → MAPPED_CNT=1.
- x=3, y=3, c=0 → cores 17, 18, 33, 34 get REQ with IDX 0x0A, 0x08, 0x02, 0x00 respectively. Ack them in order 34, 17, 33, 18 → input ACK only after the last core ACKs and all four ACKs fall.
- x=31, y=31 → only core 255 gets REQ, with dx=dy=2. No wrap to column 0.
- Type 01 → all 256 REQs high, IDX=0, EVENT=10'h1FF. Type 11 → no core REQ, input ACK after edge E+2, MAPPED_CNT unchanged.
- STRIDE=4, LRF 3×3, PAD=0, x=3 → empty mask → input ACK with no core REQ.
- Assert rst_n=0 while in ISSUE → all outputs at reset values within the same cycle. A fresh event after reset dispatches normally.

Source files
------------

// File: rtl/aer_lrf_stride_dispatcher.sv
// rtl/aer_lrf_stride_dispatcher.sv - sequential LRF stride mapper with per-core 4-phase dispatch
//
// Accepts one AER event at a time, finds every core whose receptive field
// (with stride and zero padding) covers the pixel, raises a registered 4-phase
// request to each of them and acknowledges the input only after every target
// has completed its handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   MAP_IN_AERIN_*        input AER channel (REQ/EVENT/IDX in, ACK out)
//   MAP_OUT_AERIN_*       per-core AER channels (REQ/EVENT/IDX out, ACK in)
//   BUSY                  FSM away from IDLE
//   MAPPED_CNT            completed type-00 events, wrapping
module aer_lrf_stride_dispatcher #(
  parameter int FM_W          = 32,
  parameter int FM_H          = 32,
  parameter int FM_C          = 16,
  parameter int LRF_W         = 3,
  parameter int LRF_H         = 3,
  parameter int STRIDE        = 2,
  parameter int PAD           = 1,
  parameter int IN_AER_WIDTH  = 16,
  parameter int OUT_AER_WIDTH = 10,
  localparam int CORE_W = (FM_W + 2 * PAD - LRF_W) / STRIDE + 1,
  localparam int CORE_H = (FM_H + 2 * PAD - LRF_H) / STRIDE + 1,
  localparam int N      = CORE_W * CORE_H,
  localparam int IIW    = IN_AER_WIDTH - 2,
  localparam int OIW    = OUT_AER_WIDTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       MAP_IN_AERIN_REQ,
  input  logic [IN_AER_WIDTH-1:0]    MAP_IN_AERIN_EVENT,
  input  logic [IIW-1:0]             MAP_IN_AERIN_IDX,
  output logic                       MAP_IN_AERIN_ACK,
  output logic [N-1:0]               MAP_OUT_AERIN_REQ,
  output logic [N*OUT_AER_WIDTH-1:0] MAP_OUT_AERIN_EVENT,
  output logic [N*OIW-1:0]           MAP_OUT_AERIN_IDX,
  input  logic [N-1:0]               MAP_OUT_AERIN_ACK,
  output logic                       BUSY,
  output logic [15:0]                MAPPED_CNT
);

  localparam int X_BITS  = (FM_W  > 1) ? $clog2(FM_W)  : 1;
  localparam int Y_BITS  = (FM_H  > 1) ? $clog2(FM_H)  : 1;
  localparam int C_BITS  = (FM_C  > 1) ? $clog2(FM_C)  : 1;
  localparam int DX_BITS = (LRF_W > 1) ? $clog2(LRF_W) : 1;
  localparam int DY_BITS = (LRF_H > 1) ? $clog2(LRF_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_ISSUE, S_DRAIN, S_IN_ACK} state_t;

  state_t                              state_q, state_d;
  logic                                req_in_q, req_in_d;
  logic                                ack_q, ack_d;
  logic [1:0]                          type_q, type_d;
  logic [X_BITS-1:0]                   x_q, x_d;
  logic [Y_BITS-1:0]                   y_q, y_d;
  logic [C_BITS-1:0]                   c_q, c_d;
  logic [N-1:0]                        mask_q, mask_d;
  logic [N-1:0]                        oreq_q, oreq_d;
  logic [N-1:0][OIW-1:0]               oidx_q, oidx_d;
  logic [N-1:0][OUT_AER_WIDTH-1:0]     oevt_q, oevt_d;
  logic [15:0]                         cnt_q, cnt_d;

  logic [CORE_W-1:0]                   col_hit;
  logic [DX_BITS-1:0]                  col_dx [CORE_W];
  logic [CORE_H-1:0]                   row_hit;
  logic [DY_BITS-1:0]                  row_dy [CORE_H];
  logic [N-1:0]                        tgt_hit;
  logic [N-1:0][OIW-1:0]               tgt_idx;

  // Only the type field of the input event and the {c,y,x} fields of IDX matter.
  logic unused_in;
  assign unused_in = ^{MAP_IN_AERIN_EVENT[IN_AER_WIDTH-3:0], MAP_IN_AERIN_IDX};

  // Per-axis coverage on the padded coordinate; the offset is only meaningful where hit.
  always_comb begin
    for (int ox = 0; ox < CORE_W; ox++) begin
      col_hit[ox] = (int'(x_q) + PAD >= ox * STRIDE) && (int'(x_q) + PAD - ox * STRIDE < LRF_W);
      col_dx[ox]  = DX_BITS'(int'(x_q) + PAD - ox * STRIDE);
    end
    for (int oy = 0; oy < CORE_H; oy++) begin
      row_hit[oy] = (int'(y_q) + PAD >= oy * STRIDE) && (int'(y_q) + PAD - oy * STRIDE < LRF_H);
      row_dy[oy]  = DY_BITS'(int'(y_q) + PAD - oy * STRIDE);
    end
  end

  always_comb begin
    for (int oy = 0; oy < CORE_H; oy++) begin
      for (int ox = 0; ox < CORE_W; ox++) begin
        tgt_hit[oy * CORE_W + ox] = col_hit[ox] & row_hit[oy];
        tgt_idx[oy * CORE_W + ox] = OIW'({c_q, row_dy[oy], col_dx[ox]});
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_in_d = MAP_IN_AERIN_REQ;
    ack_d    = ack_q;
    type_d   = type_q;
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    mask_d   = mask_q;
    oreq_d   = oreq_q;
    oidx_d   = oidx_q;
    oevt_d   = oevt_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_in_q) begin
          type_d  = MAP_IN_AERIN_EVENT[IN_AER_WIDTH-1 -: 2];
          x_d     = MAP_IN_AERIN_IDX[X_BITS-1:0];
          y_d     = MAP_IN_AERIN_IDX[X_BITS +: Y_BITS];
          c_d     = MAP_IN_AERIN_IDX[X_BITS + Y_BITS +: C_BITS];
          state_d = S_MAP;
        end
      end
      S_MAP: begin
        // Idle core value is {2'b11, all ones}, i.e. every bit set.
        oreq_d = '0;
        oidx_d = '0;
        oevt_d = '1;
        if (type_q == 2'b00) begin
          for (int i = 0; i < N; i++) begin
            if (tgt_hit[i]) begin
              oreq_d[i] = 1'b1;
              oidx_d[i] = tgt_idx[i];
              oevt_d[i] = {type_q, tgt_idx[i]};
            end
          end
        end else if (type_q != 2'b11) begin
          oreq_d = '1;
          for (int i = 0; i < N; i++) begin
            oevt_d[i] = {type_q, {OIW{1'b1}}};
          end
        end
        mask_d = oreq_d;
        if (oreq_d != '0) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IN_ACK;
          ack_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        // Requests only ever exist inside the mask, so stray ACKs clear nothing.
        oreq_d = oreq_q & ~MAP_OUT_AERIN_ACK;
        if (oreq_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((mask_q & MAP_OUT_AERIN_ACK) == '0) begin
          state_d = S_IN_ACK;
          ack_d   = 1'b1;
        end
      end
      S_IN_ACK: begin
        if (!req_in_q) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
          if (type_q == 2'b00) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_in_q <= 1'b0;
      ack_q    <= 1'b0;
      type_q   <= 2'b00;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      mask_q   <= '0;
      oreq_q   <= '0;
      oidx_q   <= '0;
      oevt_q   <= '1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_in_q <= req_in_d;
      ack_q    <= ack_d;
      type_q   <= type_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      mask_q   <= mask_d;
      oreq_q   <= oreq_d;
      oidx_q   <= oidx_d;
      oevt_q   <= oevt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign MAP_IN_AERIN_ACK    = ack_q;
  assign MAP_OUT_AERIN_REQ   = oreq_q;
  assign MAP_OUT_AERIN_IDX   = oidx_q;
  assign MAP_OUT_AERIN_EVENT = oevt_q;
  assign BUSY                = (state_q != S_IDLE);
  assign MAPPED_CNT          = cnt_q;

endmodule

// File: tb/tb_aer_lrf_stride_dispatcher.sv
// tb/tb_aer_lrf_stride_dispatcher.sv - randomized self-checking bench for aer_lrf_stride_dispatcher
//
// Ports of the DUT are driven/observed through tb signals; one default
// instance (stride 2, pad 1) and one stride-4/pad-0 instance for empty masks.
module tb_aer_lrf_stride_dispatcher;

  localparam int FW = 32, FH = 32, LW = 3, LH = 3, S = 2, P = 1;
  localparam int CW  = (FW + 2 * P - LW) / S + 1;
  localparam int CH  = (FH + 2 * P - LH) / S + 1;
  localparam int N   = CW * CH;
  localparam int OIW = 8;
  localparam int OW  = 10;
  localparam int N2  = ((FW - LW) / 4 + 1) * ((FH - LH) / 4 + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_req;
  logic [15:0]        in_evt;
  logic [13:0]        in_idx;
  logic               in_ack;
  logic [N-1:0]       out_req;
  logic [N*OW-1:0]    out_evt;
  logic [N*OIW-1:0]   out_idx;
  logic [N-1:0]       core_ack;
  logic               busy;
  logic [15:0]        cnt;

  logic               req2;
  logic [15:0]        evt2;
  logic [13:0]        idx2;
  logic               ack2;
  logic [N2-1:0]      oreq2;
  logic [N2*OW-1:0]   oevt2;
  logic [N2*OIW-1:0]  oidx2;
  logic [N2-1:0]      oack2;
  logic               busy2;
  logic [15:0]        cnt2;

  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [15:0]        exp_cnt  = 16'd0;
  logic [N-1:0]       exp_req;
  logic [OIW-1:0]     exp_idx [N];
  logic [OW-1:0]      exp_evt [N];
  int                 fixed_order[$];

  always #5 clk = ~clk;

  aer_lrf_stride_dispatcher dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .MAP_IN_AERIN_REQ    (in_req),
    .MAP_IN_AERIN_EVENT  (in_evt),
    .MAP_IN_AERIN_IDX    (in_idx),
    .MAP_IN_AERIN_ACK    (in_ack),
    .MAP_OUT_AERIN_REQ   (out_req),
    .MAP_OUT_AERIN_EVENT (out_evt),
    .MAP_OUT_AERIN_IDX   (out_idx),
    .MAP_OUT_AERIN_ACK   (core_ack),
    .BUSY                (busy),
    .MAPPED_CNT          (cnt)
  );

  aer_lrf_stride_dispatcher #(.STRIDE(4), .PAD(0)) dut_s4 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .MAP_IN_AERIN_REQ    (req2),
    .MAP_IN_AERIN_EVENT  (evt2),
    .MAP_IN_AERIN_IDX    (idx2),
    .MAP_IN_AERIN_ACK    (ack2),
    .MAP_OUT_AERIN_REQ   (oreq2),
    .MAP_OUT_AERIN_EVENT (oevt2),
    .MAP_OUT_AERIN_IDX   (oidx2),
    .MAP_OUT_AERIN_ACK   (oack2),
    .BUSY                (busy2),
    .MAPPED_CNT          (cnt2)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a core at (ox,oy) sees input window starting at (ox*S-P, oy*S-P).
  task automatic model(input int x, input int y, input int c, input logic [1:0] t);
    int wx, wy;
    for (int i = 0; i < N; i++) begin
      exp_req[i] = 1'b0;
      exp_idx[i] = '0;
      exp_evt[i] = 10'h3FF;
    end
    if (t == 2'b11) return;
    for (int oy = 0; oy < CH; oy++) begin
      for (int ox = 0; ox < CW; ox++) begin
        wx = ox * S - P;
        wy = oy * S - P;
        if (t != 2'b00) begin
          exp_req[oy * CW + ox] = 1'b1;
          exp_evt[oy * CW + ox] = {t, 8'hFF};
        end else if (x >= wx && x < wx + LW && y >= wy && y < wy + LH) begin
          exp_req[oy * CW + ox] = 1'b1;
          exp_idx[oy * CW + ox] = 8'(c * 16 + (y - wy) * 4 + (x - wx));
          exp_evt[oy * CW + ox] = {t, 8'(c * 16 + (y - wy) * 4 + (x - wx))};
        end
      end
    end
  endtask

  function automatic int nondef();
    int n = 0;
    for (int i = 0; i < N; i++) begin
      if (!exp_req[i] && (out_req[i] || out_idx[i*OIW +: OIW] != '0 || out_evt[i*OW +: OW] != 10'h3FF))
        n++;
    end
    return n;
  endfunction

  task automatic wait_ack(input logic val, input string tag);
    int n = 0;
    while (in_ack !== val && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, in_ack, val);
  endtask

  task automatic run_event(input int x, input int y, input int c, input logic [1:0] t);
    int  ord[$];
    int  stray;
    int  j, tmp;
    bit  grouped;
    model(x, y, c, t);
    for (int i = 0; i < N; i++) if (exp_req[i]) ord.push_back(i);
    if (fixed_order.size() != 0) begin
      ord = fixed_order;
      fixed_order.delete();
    end else begin
      for (int i = ord.size() - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    end
    grouped = (ord.size() > 8);
    stray = -1;
    if (!grouped && $urandom_range(1, 0) == 1) begin
      do stray = $urandom_range(N - 1, 0); while (exp_req[stray]);
      core_ack[stray] = 1'b1;
    end
    in_idx = 14'(c * 1024 + y * 32 + x);
    in_evt = {t, 14'($urandom)};
    in_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("ack_before_map", in_ack, 1'b0);
    @(posedge clk); #1;
    check_eq("busy_map", busy, 1'b1);
    check_eq("req_vec", out_req, exp_req);
    check_eq("nontarget_default", nondef(), 0);
    for (int i = 0; i < N; i++) begin
      if (exp_req[i]) begin
        check_eq("tgt_idx", out_idx[i*OIW +: OIW], exp_idx[i]);
        check_eq("tgt_evt", out_evt[i*OW +: OW], exp_evt[i]);
      end
    end
    if (ord.size() == 0) begin
      check_eq("ack_empty_mask", in_ack, 1'b1);
    end else begin
      check_eq("ack_while_issue", in_ack, 1'b0);
      if (grouped) begin
        foreach (ord[k]) core_ack[ord[k]] = 1'b1;
        @(posedge clk); #1;
        check_eq("req_all_drop", out_req, 0);
        check_eq("ack_group_drain", in_ack, 1'b0);
        foreach (ord[k]) core_ack[ord[k]] = 1'b0;
        @(posedge clk); #1;
      end else begin
        foreach (ord[k]) begin
          repeat ($urandom_range(3, 1)) @(posedge clk);
          #1;
          core_ack[ord[k]] = 1'b1;
          @(posedge clk); #1;
          check_eq("req_drop", out_req[ord[k]], 1'b0);
          check_eq("ack_during_issue", in_ack, 1'b0);
        end
        check_eq("req_vec_clear", out_req, 0);
        foreach (ord[k]) begin
          repeat ($urandom_range(3, 1)) @(posedge clk);
          #1;
          check_eq("ack_before_drain", in_ack, 1'b0);
          core_ack[ord[k]] = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    wait_ack(1'b1, "in_ack_rise");
    in_idx = 14'($urandom);
    in_evt = 16'($urandom);
    in_req = 1'b0;
    wait_ack(1'b0, "in_ack_fall");
    if (t == 2'b00) exp_cnt = exp_cnt + 16'd1;
    check_eq("mapped_cnt", cnt, exp_cnt);
    check_eq("busy_idle", busy, 1'b0);
    if (stray >= 0) core_ack[stray] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t;
    rst_n = 1'b0; in_req = 1'b0; in_evt = '0; in_idx = '0; core_ack = '0;
    req2 = 1'b0; evt2 = '0; idx2 = '0; oack2 = '0;
    repeat (3) @(posedge clk);
    #1;
    model(0, 0, 0, 2'b11);
    check_eq("rst_req", out_req, 0);
    check_eq("rst_ack", in_ack, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cnt", cnt, 16'd0);
    check_eq("rst_outputs_default", nondef(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_event(0, 0, 3, 2'b00);
    check_eq("core0_idx", out_idx[7:0], 8'h35);
    fixed_order = '{34, 17, 33, 18};
    run_event(3, 3, 0, 2'b00);
    run_event(31, 31, 5, 2'b00);
    run_event(7, 9, 2, 2'b01);
    run_event(12, 4, 1, 2'b11);
    run_event(5, 20, 6, 2'b10);
    for (int r = 0; r < 30; r++) begin
      t = ($urandom_range(9, 0) < 7) ? 2'b00 : 2'($urandom_range(3, 1));
      run_event($urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(15, 0), t);
    end

    // Stride 4 without padding leaves x=3 outside every window.
    idx2 = 14'(2 * 1024 + 3 * 32 + 3);
    evt2 = 16'h0000;
    req2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("s4_ack_empty", ack2, 1'b1);
    check_eq("s4_no_req", oreq2, 0);
    req2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("s4_ack_fall", ack2, 1'b0);
    check_eq("s4_cnt", cnt2, 16'd1);

    // Abort mid-ISSUE with an asynchronous reset.
    model(3, 3, 1, 2'b00);
    in_idx = 14'(1 * 1024 + 3 * 32 + 3);
    in_evt = 16'h0000;
    in_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_req", out_req, exp_req);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    model(0, 0, 0, 2'b11);
    check_eq("abort_req", out_req, 0);
    check_eq("abort_ack", in_ack, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_cnt", cnt, 16'd0);
    check_eq("abort_outputs_default", nondef(), 0);
    in_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("no_ack_after_abort", in_ack, 1'b0);
    run_event(3, 3, 9, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
